// File: rtl/lc3_branch_resolve.sv
// lc3_branch_resolve
//   Resolves LC-3 BR instructions. A BR is held until every condition-code
//   writer issued ahead of it has written the NZP register. It is then
//   evaluated against the registered flags, and a taken branch produces a
//   fetch redirect.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   ir, ir_valid, ir_ready  instruction input handshake from decode
//   pc_inc                  incremented PC belonging to ir
//   n_flag, z_flag, p_flag  registered condition codes
//   cc_wr_issue             pulse: one CC-writing instruction issued
//   cc_wr_done              pulse: the CC register is written at this edge
//   resolve_valid/_taken    one-cycle resolution pulse and its result
//   redirect_valid/_ready   fetch redirect handshake
//   redirect_pc             redirect target; holds its last value when idle
//   cc_err                  sticky outstanding-writer counter under/overflow
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload stable until that edge.
// Ready never depends on valid. Every output here is a flop or a decode of
// the state register.

module lc3_branch_resolve (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        ir_valid,
  output logic        ir_ready,
  input  logic [15:0] pc_inc,
  input  logic        n_flag,
  input  logic        z_flag,
  input  logic        p_flag,
  input  logic        cc_wr_issue,
  input  logic        cc_wr_done,
  output logic        resolve_valid,
  output logic        resolve_taken,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [15:0] redirect_pc,
  output logic        cc_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_RESOLVE  = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] target_q, target_d;
  logic [15:0] redirect_pc_q, redirect_pc_d;
  logic        taken_q, taken_d;
  logic        cc_err_q, cc_err_d;

  logic        br_xfer;
  logic [2:0]  br_nzp;
  logic [15:0] br_target;
  logic [2:0]  wait_sum;
  logic [1:0]  wait_init;

  function automatic logic eval_taken(input logic [2:0] nzp,
                                      input logic n, input logic z,
                                      input logic p);
    return (nzp[2] & n) | (nzp[1] & z) | (nzp[0] & p);
  endfunction

  assign br_nzp    = ir[11:9];
  assign br_target = pc_inc + {{7{ir[8]}}, ir[8:0]};
  assign br_xfer   = ir_valid && (state_q == ST_IDLE) && (ir[15:12] == 4'b0000);

  // Writers still outstanding once this edge completes. An issue in the
  // same cycle as the BR is older than the BR, so it must be waited for.
  always_comb begin
    wait_sum = {1'b0, pend_q} + {2'b00, cc_wr_issue};
    if (cc_wr_done && (wait_sum != 3'd0)) begin
      wait_sum = wait_sum - 3'd1;
    end
    wait_init = (wait_sum > 3'd3) ? 2'd3 : wait_sum[1:0];
  end

  // Outstanding CC-writer counter. It saturates at both ends and flags the
  // event, because a lost pulse means the interlock can no longer be trusted.
  always_comb begin
    pend_d   = pend_q;
    cc_err_d = cc_err_q;
    if (cc_wr_issue && !cc_wr_done) begin
      if (pend_q == 2'd3) cc_err_d = 1'b1;
      else                pend_d   = pend_q + 2'd1;
    end else if (!cc_wr_issue && cc_wr_done) begin
      if (pend_q == 2'd0) cc_err_d = 1'b1;
      else                pend_d   = pend_q - 2'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    nzp_d         = nzp_q;
    target_d      = target_q;
    taken_d       = taken_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        // A non-BR that is accepted is simply dropped here.
        if (br_xfer) begin
          target_d   = br_target;
          nzp_d      = br_nzp;
          wait_cnt_d = wait_init;
          if (wait_init == 2'd0) begin
            state_d = ST_RESOLVE;
            taken_d = eval_taken(br_nzp, n_flag, z_flag, p_flag);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Only writers older than the branch count down. Newer issues
        // change pend but never this count.
        if (wait_cnt_q == 2'd0) begin
          state_d = ST_RESOLVE;
          taken_d = eval_taken(nzp_q, n_flag, z_flag, p_flag);
        end else if (cc_wr_done) begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      ST_RESOLVE: begin
        if (taken_q) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = target_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pend_q        <= 2'd0;
      wait_cnt_q    <= 2'd0;
      nzp_q         <= 3'b000;
      target_q      <= 16'h0000;
      redirect_pc_q <= 16'h0000;
      taken_q       <= 1'b0;
      cc_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      wait_cnt_q    <= wait_cnt_d;
      nzp_q         <= nzp_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      taken_q       <= taken_d;
      cc_err_q      <= cc_err_d;
    end
  end

  assign ir_ready       = (state_q == ST_IDLE);
  assign resolve_valid  = (state_q == ST_RESOLVE);
  // taken_q is left over after a resolution, so it is gated to RESOLVE.
  assign resolve_taken  = (state_q == ST_RESOLVE) & taken_q;
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign cc_err         = cc_err_q;

endmodule

// File: tb/tb_lc3_branch_resolve.sv
// Testbench for lc3_branch_resolve.
//   Directed scenarios are followed by randomized BR/non-BR traffic. Every
//   expectation comes from a small model of the branch rules: the count of
//   outstanding writers, the sign-extended target and the NZP match.

module tb_lc3_branch_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        ir_valid = 1'b0;
  logic        ir_ready;
  logic [15:0] pc_inc = 16'h0000;
  logic        n_flag = 1'b0, z_flag = 1'b0, p_flag = 1'b0;
  logic        cc_wr_issue = 1'b0, cc_wr_done = 1'b0;
  logic        resolve_valid, resolve_taken, redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [15:0] redirect_pc;
  logic        cc_err;

  // reference model state
  int          pend_m = 0;
  logic        err_m = 1'b0;
  logic [15:0] exp_rpc = 16'h0000;

  int n_pass = 0;
  int n_total = 0;

  lc3_branch_resolve dut (
    .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .pc_inc(pc_inc), .n_flag(n_flag), .z_flag(z_flag), .p_flag(p_flag),
    .cc_wr_issue(cc_wr_issue), .cc_wr_done(cc_wr_done),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .cc_err(cc_err)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_issue();
    if (pend_m == 3) err_m = 1'b1;
    else pend_m++;
  endtask

  task automatic model_done();
    if (pend_m == 0) err_m = 1'b1;
    else pend_m--;
  endtask

  task automatic pulse_issue();
    cc_wr_issue = 1'b1; step(); cc_wr_issue = 1'b0;
    model_issue();
  endtask

  task automatic pulse_done();
    cc_wr_done = 1'b1; step(); cc_wr_done = 1'b0;
    model_done();
  endtask

  task automatic discard(input logic [15:0] instr);
    ir = instr; pc_inc = 16'($urandom); ir_valid = 1'b1;
    step();
    ir_valid = 1'b0;
    chk("nonbr_ready", ir_ready, 1);
    chk("nonbr_resolve", resolve_valid, 0);
    chk("nonbr_redirect", redirect_valid, 0);
    chk("nonbr_pc", redirect_pc, exp_rpc);
    step();
    chk("nonbr_resolve2", resolve_valid, 0);
  endtask

  // Full BR transaction: transfer, wait for older CC writers, resolve, and
  // redirect if taken, with redirect_ready held low for 'hold' extra cycles.
  task automatic run_br(input logic [15:0] instr, input logic [15:0] pc,
                        input int hold, input bit co_issue, input bit mid_issue,
                        input logic [2:0] post_flags);
    int w;
    int o;
    logic [2:0]  nzp;
    logic [15:0] tgt;
    bit tk;
    nzp = instr[11:9];
    o = int'(instr[8:0]);
    if (o > 255) o = o - 512;
    tgt = 16'(int'(pc) + o);
    chk("pre_ready", ir_ready, 1);
    w = pend_m + (co_issue ? 1 : 0);
    if (w > 3) w = 3;
    ir = instr; pc_inc = pc; ir_valid = 1'b1; cc_wr_issue = co_issue;
    step();
    cc_wr_issue = 1'b0;
    if (co_issue) model_issue();
    // keep offering another BR while busy; it must not be taken
    ir = {4'b0000, 12'($urandom)};
    if (w > 0) begin
      for (int i = 0; i < w; i++) begin
        chk("wait_ready", ir_ready, 0);
        chk("wait_resolve", resolve_valid, 0);
        chk("wait_redirect", redirect_valid, 0);
        if (mid_issue && i == 0) begin
          pulse_issue();
          chk("wait_after_issue", resolve_valid, 0);
        end
        pulse_done();
      end
      {n_flag, z_flag, p_flag} = post_flags;
      chk("wait_last", resolve_valid, 0);
      step();
    end
    tk = (nzp & {n_flag, z_flag, p_flag}) != 3'b000;
    chk("res_valid", resolve_valid, 1);
    chk("res_taken", resolve_taken, tk);
    chk("res_ready", ir_ready, 0);
    chk("res_redirect", redirect_valid, 0);
    step();
    if (tk) begin
      exp_rpc = tgt;
      for (int i = 0; i <= hold; i++) begin
        chk("rd_valid", redirect_valid, 1);
        chk("rd_pc", redirect_pc, exp_rpc);
        chk("rd_resolve", resolve_valid, 0);
        chk("rd_taken", resolve_taken, 0);
        if (i < hold) step();
      end
      redirect_ready = 1'b1; ir_valid = 1'b0;
      step();
      redirect_ready = 1'b0;
    end
    ir_valid = 1'b0;
    chk("end_ready", ir_ready, 1);
    chk("end_redirect", redirect_valid, 0);
    chk("end_pc", redirect_pc, exp_rpc);
    chk("end_resolve", resolve_valid, 0);
    chk("end_cc_err", cc_err, err_m);
  endtask

  initial begin
    logic [15:0] instr;
    bit co, mid;

    // reset
    repeat (2) step();
    chk("rst_resolve", resolve_valid, 0);
    chk("rst_taken", resolve_taken, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 16'h0000);
    chk("rst_cc_err", cc_err, 0);
    reset = 1'b0;
    chk("rst_ready", ir_ready, 1);
    step();

    // taken forward, then the same branch not taken
    {n_flag, z_flag, p_flag} = 3'b001;
    run_br(16'h0A05, 16'h3001, 3, 0, 0, 3'b001);
    {n_flag, z_flag, p_flag} = 3'b010;
    run_br(16'h0A05, 16'h3001, 0, 0, 0, 3'b010);
    discard(16'h1234);

    // negative offset and wrap-around
    {n_flag, z_flag, p_flag} = 3'b001;
    run_br(16'h0FFE, 16'h3001, 1, 0, 0, 3'b001);
    run_br(16'h0FFF, 16'h0000, 0, 0, 0, 3'b001);

    // nzp=000 never taken, nzp=111 taken for every valid flag
    {n_flag, z_flag, p_flag} = 3'b111;
    run_br(16'h0155, 16'h1000, 0, 0, 0, 3'b111);
    for (int f = 0; f < 3; f++) begin
      {n_flag, z_flag, p_flag} = 3'b001 << f;
      run_br(16'h0E10, 16'h2000 + 16'(f), 0, 0, 0, 3'b001);
    end

    // CC interlock: two older writers, a newer one issued during WAIT
    pulse_issue(); pulse_issue();
    {n_flag, z_flag, p_flag} = 3'b010;
    run_br(16'h0203, 16'h4000, 1, 0, 1, 3'b001);
    pulse_done();

    // issue coinciding with the BR transfer is an older writer
    run_br(16'h0E02, 16'h5000, 1, 1, 0, 3'b010);

    // underflow sets the sticky error
    chk("pre_underflow_err", cc_err, 0);
    pulse_done();
    chk("underflow_err", cc_err, 1);
    repeat (3) step();
    chk("underflow_sticky", cc_err, 1);

    // reset while in REDIRECT
    {n_flag, z_flag, p_flag} = 3'b001;
    ir = 16'h0E07; pc_inc = 16'h6000; ir_valid = 1'b1;
    step();
    ir_valid = 1'b0;
    chk("rr_resolve", resolve_valid, 1);
    step();
    chk("rr_redirect", redirect_valid, 1);
    chk("rr_pc", redirect_pc, 16'h6007);
    #2 reset = 1'b1;
    #1;
    chk("rr_async_redirect", redirect_valid, 0);
    chk("rr_async_cc_err", cc_err, 0);
    chk("rr_async_pc", redirect_pc, 16'h0000);
    chk("rr_async_ready", ir_ready, 1);
    pend_m = 0; err_m = 1'b0; exp_rpc = 16'h0000;
    step();
    reset = 1'b0;
    chk("rr_release_ready", ir_ready, 1);

    // reset mid-WAIT: the held branch and pend must both be gone
    pulse_issue(); pulse_issue();
    ir = 16'h0E04; ir_valid = 1'b1;
    step();
    ir_valid = 1'b0;
    chk("rw_waiting", ir_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("rw_async_ready", ir_ready, 1);
    pend_m = 0; err_m = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_no_resolve", resolve_valid, 0);
      chk("rw_no_redirect", redirect_valid, 0);
    end
    run_br(16'h0E10, 16'h7000, 0, 0, 0, 3'b001);

    // overflow: pend saturates at 3, so the branch waits for three dones
    repeat (4) pulse_issue();
    chk("overflow_err", cc_err, 1);
    run_br(16'h0E01, 16'h8000, 0, 0, 0, 3'b100);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        discard({4'($urandom_range(1, 15)), 12'($urandom)});
      end else begin
        repeat ($urandom_range(0, 2)) pulse_issue();
        {n_flag, z_flag, p_flag} = 3'($urandom);
        instr = {4'b0000, 12'($urandom)};
        co  = (pend_m < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        mid = 1'($urandom_range(0, 1));
        run_br(instr, 16'($urandom), $urandom_range(0, 3), co, mid, 3'($urandom));
        while (pend_m > 0) pulse_done();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
